// File: rtl/pipe_trace_checker_if.sv
// Signal bundle between the trace checker and its driver (processor top or bench).
// With TRACE_SNAPSHOT_EN defined the bundle also carries the snapshot read port.
interface pipe_trace_checker_if #(
   parameter int DATA_W = 32,
   parameter int NUM_CH = 3,
   parameter int CYC_W  = 8
);
   logic                     start;
   logic                     abort;
   logic [DATA_W-1:0]        start_pc;
   logic [CYC_W-1:0]         check_cycle;
   logic [NUM_CH-1:0]        exp_mask;
   logic [NUM_CH*DATA_W-1:0] exp_data;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic                     pc_load;
   logic [DATA_W-1:0]        pc_out;
   logic [CYC_W-1:0]         cycle_cnt;
   logic                     busy;
   logic                     done;
   logic                     pass;
   logic [NUM_CH-1:0]        mismatch;
   logic                     check_missed;
   logic                     stop_req;
   logic [1:0]               dbg_state;
`ifdef TRACE_SNAPSHOT_EN
   logic [CYC_W-1:0]         snap_idx;
   logic [NUM_CH*DATA_W-1:0] snap_data;
`endif

   // start is a single-cycle request with no ready: it is taken only in IDLE/DONE
   // and silently dropped otherwise; abort has priority over start in every state.
   modport master (
      output start, abort, start_pc, check_cycle, exp_mask, exp_data, ch_data,
      input  pc_load, pc_out, cycle_cnt, busy, done, pass, mismatch, check_missed,
             stop_req, dbg_state
`ifdef TRACE_SNAPSHOT_EN
      , output snap_idx, input snap_data
`endif
   );

   modport slave (
      input  start, abort, start_pc, check_cycle, exp_mask, exp_data, ch_data,
      output pc_load, pc_out, cycle_cnt, busy, done, pass, mismatch, check_missed,
             stop_req, dbg_state
`ifdef TRACE_SNAPSHOT_EN
      , input snap_idx, output snap_data
`endif
   );
endinterface

// File: rtl/pipe_trace_checker.sv
// Instruction-trace checker: launches a PC, counts MAX_CYCLES pipeline cycles and
// compares NUM_CH watched registers at one cycle. TRACE_SNAPSHOT_EN adds a per-cycle buffer.
module pipe_trace_checker #(
   parameter int DATA_W     = 32,
   parameter int NUM_CH     = 3,
   parameter int CYC_W      = 8,
   parameter int MAX_CYCLES = 6,
   parameter int SNAP_DEPTH = 8
) (
   input logic clk,
   input logic rst_n,
   pipe_trace_checker_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [CYC_W-1:0] LP_MAX = CYC_W'(MAX_CYCLES);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [CYC_W-1:0]         r_cc_q;
   logic [NUM_CH-1:0]        r_mask_q;
   logic [NUM_CH*DATA_W-1:0] r_exp_q;
   logic [CYC_W-1:0]         r_cnt;
   logic [DATA_W-1:0]        r_pc;
   logic                     r_pc_load;
   logic                     r_busy;
   logic                     r_done;
   logic                     r_pass;
   logic [NUM_CH-1:0]        r_mis;
   logic                     r_missed;
   logic                     r_stop;

   logic                     w_launch;
   logic                     w_end;
   logic                     w_hit;
   logic                     w_missed;
   logic [CYC_W-1:0]         w_cnt_inc;
   logic [NUM_CH-1:0]        w_mis_nxt;

   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_launch  = bus.start & ~bus.abort & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign w_end     = (r_state == S_RUN) & ~bus.abort & (w_cnt_inc == LP_MAX);
   assign w_hit     = (r_state == S_RUN) & (r_cnt == r_cc_q);
   assign w_missed  = (r_cc_q == '0) | (r_cc_q >= LP_MAX);

   always_comb begin
      w_mis_nxt = r_mis;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_hit && r_mask_q[i] &&
             (bus.ch_data[i*DATA_W +: DATA_W] != r_exp_q[i*DATA_W +: DATA_W]))
            w_mis_nxt[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: if (bus.start) w_state_nxt = S_LOAD;
            S_LOAD:         w_state_nxt = S_RUN;
            S_RUN:          if (w_cnt_inc == LP_MAX) w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cc_q    <= '0;
         r_mask_q  <= '0;
         r_exp_q   <= '0;
         r_cnt     <= '0;
         r_pc      <= '0;
         r_pc_load <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_mis     <= '0;
         r_missed  <= 1'b0;
         r_stop    <= 1'b0;
      end else if (bus.abort) begin
         // cycle_cnt and mismatch are left frozen so the aborted run can be inspected
         r_pc_load <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_missed  <= 1'b0;
         r_stop    <= 1'b0;
      end else if (w_launch) begin
         r_cc_q    <= bus.check_cycle;
         r_mask_q  <= bus.exp_mask;
         r_exp_q   <= bus.exp_data;
         r_cnt     <= CYC_W'(1);
         r_pc      <= bus.start_pc;
         r_pc_load <= 1'b1;
         r_busy    <= 1'b1;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_mis     <= '0;
         r_missed  <= 1'b0;
         r_stop    <= 1'b0;
      end else begin
         r_pc_load <= 1'b0;
         r_stop    <= 1'b0;
         if (r_state == S_RUN) begin
            r_mis <= w_mis_nxt;
            r_cnt <= w_cnt_inc;
         end
         if (w_end) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_stop   <= 1'b1;
            r_missed <= w_missed;
            r_pass   <= ~(|w_mis_nxt) & ~w_missed;
         end
      end
   end

   assign bus.pc_load      = r_pc_load;
   assign bus.pc_out       = r_pc;
   assign bus.cycle_cnt    = r_cnt;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.pass         = r_pass;
   assign bus.mismatch     = r_mis;
   assign bus.check_missed = r_missed;
   assign bus.stop_req     = r_stop;
   assign bus.dbg_state    = r_state;

`ifdef TRACE_SNAPSHOT_EN
   localparam int SNAP_AW = (SNAP_DEPTH > 1) ? $clog2(SNAP_DEPTH) : 1;

   // No reset on the buffer: entries are only meaningful once a run has written them.
   logic [NUM_CH*DATA_W-1:0] r_snap [SNAP_DEPTH];

   always_ff @(posedge clk) begin
      if (r_state == S_RUN && r_cnt < CYC_W'(SNAP_DEPTH))
         r_snap[r_cnt[SNAP_AW-1:0]] <= bus.ch_data;
   end

   assign bus.snap_data = (bus.snap_idx < CYC_W'(SNAP_DEPTH)) ?
                          r_snap[bus.snap_idx[SNAP_AW-1:0]] : '0;
`endif
endmodule

// File: tb/tb_pipe_trace_checker.sv
// Randomised bench for pipe_trace_checker against a per-run reference model.
// Define TRACE_SNAPSHOT_EN to build the 8-channel, 20-cycle snapshot configuration.
module tb_pipe_trace_checker;
`ifdef TRACE_SNAPSHOT_EN
   localparam int NC   = 8;
   localparam int MAXC = 20;
   localparam int SNAP = 20;
`else
   localparam int NC   = 3;
   localparam int MAXC = 6;
   localparam int SNAP = 8;
`endif
   localparam int DW = 32;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipe_trace_checker_if #(.DATA_W(DW), .NUM_CH(NC), .CYC_W(CW)) bus ();

   pipe_trace_checker #(
      .DATA_W(DW), .NUM_CH(NC), .CYC_W(CW), .MAX_CYCLES(MAXC), .SNAP_DEPTH(SNAP)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // plan for the next run: what the driver applies and what the model judges
   int                   m_cc;
   logic [NC-1:0]        m_mask;
   logic [NC*DW-1:0]     m_exp;
   logic [DW-1:0]        m_pc;
   logic [NC*DW-1:0]     ch_seq [0:MAXC];

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_missed();
      return (m_cc == 0) || (m_cc >= MAXC);
   endfunction

   // mismatch flags after the compares of every cycle below 'limit' have happened
   function automatic logic [NC-1:0] model_mis(input int limit);
      logic [NC-1:0] r = '0;
      if (m_cc >= 1 && m_cc < limit && m_cc < MAXC)
         for (int i = 0; i < NC; i++)
            if (m_mask[i] && ch_seq[m_cc][i*DW +: DW] != m_exp[i*DW +: DW]) r[i] = 1'b1;
      return r;
   endfunction

   task automatic gen_random_plan(input int cc);
      m_cc   = cc;
      m_mask = NC'($urandom);
      m_pc   = $urandom;
      for (int i = 0; i < NC; i++) m_exp[i*DW +: DW] = $urandom;
      for (int c = 0; c <= MAXC; c++)
         for (int i = 0; i < NC; i++)
            ch_seq[c][i*DW +: DW] = ($urandom_range(0, 1) == 1) ? m_exp[i*DW +: DW] : $urandom;
   endtask

   // stl-style program: ch0=s7 (flag set at cycle 4 when taken), ch1=s5, ch2=s6
   task automatic gen_stl_plan(input logic taken, input logic [NC-1:0] mask);
      m_cc   = 5;
      m_mask = mask;
      m_pc   = 32'h0054;
      m_exp  = '0;
      m_exp[0*DW +: DW] = 1;
      m_exp[1*DW +: DW] = taken ? 5 : 9;
      m_exp[2*DW +: DW] = taken ? 9 : 5;
      for (int c = 0; c <= MAXC; c++) begin
         ch_seq[c] = '0;
         ch_seq[c][0*DW +: DW] = (taken && c >= 4) ? 1 : 0;
         ch_seq[c][1*DW +: DW] = taken ? 5 : 9;
         ch_seq[c][2*DW +: DW] = taken ? 9 : 5;
      end
   endtask

   task automatic drive_idle();
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.start_pc    = '0;
      bus.check_cycle = '0;
      bus.exp_mask    = '0;
      bus.exp_data    = '0;
      bus.ch_data     = '0;
`ifdef TRACE_SNAPSHOT_EN
      bus.snap_idx    = '0;
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".pc_load"},  bus.pc_load,      0);
      chk({tag, ".pc_out"},   bus.pc_out,       0);
      chk({tag, ".cnt"},      bus.cycle_cnt,    0);
      chk({tag, ".busy"},     bus.busy,         0);
      chk({tag, ".done"},     bus.done,         0);
      chk({tag, ".pass"},     bus.pass,         0);
      chk({tag, ".mismatch"}, bus.mismatch,     0);
      chk({tag, ".missed"},   bus.check_missed, 0);
      chk({tag, ".stop"},     bus.stop_req,     0);
   endtask

   task automatic launch();
      @(negedge clk);
      bus.start       = 1'b1;
      bus.abort       = 1'b0;
      bus.start_pc    = m_pc;
      bus.check_cycle = CW'(m_cc);
      bus.exp_mask    = m_mask;
      bus.exp_data    = m_exp;
      bus.ch_data     = {NC{32'hdead_beef}};
      @(posedge clk); #1;
      chk("launch.pc_load",  bus.pc_load,   1);
      chk("launch.pc_out",   bus.pc_out,    m_pc);
      chk("launch.cnt",      bus.cycle_cnt, 1);
      chk("launch.busy",     bus.busy,      1);
      chk("launch.done",     bus.done,      0);
      chk("launch.mismatch", bus.mismatch,  0);
      @(negedge clk);
      // the run must only use the values captured at launch
      bus.start       = 1'b0;
      bus.start_pc    = $urandom;
      bus.check_cycle = CW'($urandom);
      bus.exp_mask    = NC'($urandom);
      for (int i = 0; i < NC; i++) bus.exp_data[i*DW +: DW] = $urandom;
      @(posedge clk); #1;
      chk("load.pc_load", bus.pc_load,   0);
      chk("load.cnt",     bus.cycle_cnt, 1);
   endtask

   // abort_at = 0 runs to completion; otherwise abort+start arrive at that cycle
   task automatic do_run(input int abort_at);
      launch();
      for (int c = 1; c < MAXC; c++) begin
         @(negedge clk);
         bus.ch_data = ch_seq[c];
         if (c == abort_at) begin
            bus.abort = 1'b1;
            bus.start = 1'b1;
         end else begin
            bus.start = (c == 2 && $urandom_range(0, 3) == 0);
         end
         @(posedge clk); #1;
         if (c == abort_at) begin
            chk("abort.busy",     bus.busy,      0);
            chk("abort.done",     bus.done,      0);
            chk("abort.pass",     bus.pass,      0);
            chk("abort.stop",     bus.stop_req,  0);
            chk("abort.cnt",      bus.cycle_cnt, c);
            chk("abort.mismatch", bus.mismatch,  model_mis(c));
            @(negedge clk);
            bus.abort = 1'b0;
            bus.start = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(posedge clk); #1;
               chk("idle.stop", bus.stop_req, 0);
               chk("idle.done", bus.done,     0);
               chk("idle.busy", bus.busy,     0);
            end
            return;
         end
         if (c < MAXC - 1) begin
            chk("run.cnt",  bus.cycle_cnt, c + 1);
            chk("run.busy", bus.busy,      1);
            chk("run.stop", bus.stop_req,  0);
         end
      end
      chk("end.stop",     bus.stop_req,     1);
      chk("end.done",     bus.done,         1);
      chk("end.busy",     bus.busy,         0);
      chk("end.cnt",      bus.cycle_cnt,    MAXC);
      chk("end.mismatch", bus.mismatch,     model_mis(MAXC));
      chk("end.missed",   bus.check_missed, model_missed());
      chk("end.pass",     bus.pass,         (model_mis(MAXC) == 0) && !model_missed());
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk); #1;
      chk("hold.stop", bus.stop_req, 0);
      chk("hold.done", bus.done,     1);
      chk("hold.pass", bus.pass,     (model_mis(MAXC) == 0) && !model_missed());
`ifdef TRACE_SNAPSHOT_EN
      for (int idx = 1; idx < MAXC; idx++) begin
         bus.snap_idx = CW'(idx);
         #1;
         chk("snap.data", bus.snap_data, ch_seq[idx]);
      end
      bus.snap_idx = CW'(SNAP);
      #1;
      chk("snap.oob", bus.snap_data, 0);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      drive_idle();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      gen_stl_plan(1'b1, NC'(3'b111));
      do_run(0);
      gen_stl_plan(1'b0, NC'(3'b111));
      do_run(0);
      gen_stl_plan(1'b0, NC'(3'b110));
      do_run(0);

      gen_random_plan(0);
      do_run(0);
      gen_random_plan(MAXC + 1);
      do_run(0);
      gen_random_plan(MAXC);
      do_run(0);
      gen_random_plan(MAXC - 1);
      m_mask = '0;
      do_run(0);

      gen_random_plan(2);
      do_run(3);
      gen_stl_plan(1'b1, NC'(3'b111));
      do_run(0);

      // asynchronous reset while cycle_cnt is 2
      gen_random_plan(1);
      launch();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      gen_stl_plan(1'b1, NC'(3'b111));
      do_run(0);

`ifdef TRACE_SNAPSHOT_EN
      gen_random_plan(7);
      m_mask = '1;
      for (int c = 0; c <= MAXC; c++) ch_seq[c] = m_exp;
      ch_seq[7][7*DW +: DW] = ~m_exp[7*DW +: DW];
      do_run(0);
      chk("ch7.mismatch", bus.mismatch, NC'(1) << 7);
`endif

      for (int r = 0; r < 20; r++) begin
         gen_random_plan($urandom_range(0, MAXC + 1));
         do_run(($urandom_range(0, 4) == 0) ? $urandom_range(1, MAXC - 1) : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
